// File: rtl/dp_axis_polyvec_loader_pkg.sv
// Shared FSM encoding, default sizing and helpers for the polyvec loader.
package dp_axis_polyvec_loader_pkg;

  localparam int DEF_COE_WIDTH     = 39;
  localparam int DEF_ADDR_WIDTH    = 9;
  localparam int DEF_NUM_POLY      = 3;
  localparam int DEF_NUM_BASE_BANK = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Poly counter width, kept at least one bit for single-poly builds.
  function automatic int poly_width(input int num_poly);
    return (num_poly > 1) ? $clog2(num_poly) : 1;
  endfunction

endpackage

// File: rtl/dp_axis_polyvec_loader_if.sv
// AXI-Stream coefficient beat channel feeding the polyvec loader.
interface dp_axis_polyvec_loader_if #(
  parameter int COE_WIDTH     = dp_axis_polyvec_loader_pkg::DEF_COE_WIDTH,
  parameter int NUM_BASE_BANK = dp_axis_polyvec_loader_pkg::DEF_NUM_BASE_BANK
);
  logic [COE_WIDTH*NUM_BASE_BANK-1:0] tdata;
  logic                               tvalid;
  logic                               tlast;
  logic                               tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dp_axis_polyvec_loader_addr_gen.sv
// Row and poly counters with wrap/last flags for the polyvec loader.
// Define DP_LOADER_BITREV_EN to emit bit-reversed row addresses (NTT input order).
module dp_axis_polyvec_loader_addr_gen
  import dp_axis_polyvec_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_POLY   = DEF_NUM_POLY,
  localparam int PW        = poly_width(NUM_POLY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [PW-1:0]         poly_cnt,
  output logic                  addr_last,
  output logic                  vec_last
);

  logic [ADDR_WIDTH-1:0] addr_cnt_reg;
  logic [PW-1:0]         poly_cnt_reg;
  logic                  poly_last;

  assign addr_last = (addr_cnt_reg == {ADDR_WIDTH{1'b1}});
  assign poly_last = (poly_cnt_reg == PW'(NUM_POLY - 1));
  assign vec_last  = addr_last && poly_last;
  assign poly_cnt  = poly_cnt_reg;

  // Row counter wraps naturally at DEPTH; the poly counter steps on each row wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      addr_cnt_reg <= '0;
      poly_cnt_reg <= '0;
    end else if (adv) begin
      addr_cnt_reg <= addr_cnt_reg + ADDR_WIDTH'(1);
      if (addr_last) begin
        poly_cnt_reg <= poly_last ? '0 : poly_cnt_reg + PW'(1);
      end
    end
  end

`ifdef DP_LOADER_BITREV_EN
  for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_rev
    assign wr_addr[gi] = addr_cnt_reg[ADDR_WIDTH-1-gi];
  end
`else
  assign wr_addr = addr_cnt_reg;
`endif

endmodule

// File: rtl/dp_axis_polyvec_loader.sv
// Streams coefficient beats into per-poly bank writes and pulses o_done per polyvec.
// Optional DP_LOADER_BITREV_EN (in the address generator) bit-reverses row addresses.
module dp_axis_polyvec_loader
  import dp_axis_polyvec_loader_pkg::*;
#(
  parameter int COE_WIDTH     = DEF_COE_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int NUM_POLY      = DEF_NUM_POLY,
  parameter int NUM_BASE_BANK = DEF_NUM_BASE_BANK
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_start,
  dp_axis_polyvec_loader_if.slave             s_axis,
  output logic [NUM_BASE_BANK*NUM_POLY-1:0]   o_axi_we,
  output logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] o_axi_wraddr,
  output logic [COE_WIDTH*NUM_BASE_BANK-1:0]  o_axi_data,
  output logic                                o_done,
  output logic                                o_busy,
  output logic                                o_err
);

  localparam int PW   = poly_width(NUM_POLY);
  localparam int WE_W = NUM_BASE_BANK * NUM_POLY;

  state_t                              state_reg, state_next;
  logic                                in_load, accept, clr;
  logic [ADDR_WIDTH-1:0]               wr_addr;
  logic [PW-1:0]                       poly_cnt;
  logic                                addr_last, vec_last;
  logic [WE_W-1:0]                     we_reg, we_next;
  logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] wraddr_reg;
  logic [COE_WIDTH*NUM_BASE_BANK-1:0]  data_reg;
  logic                                err_reg;

  assign in_load       = (state_reg == ST_LOAD);
  assign s_axis.tready = in_load;
  assign accept        = s_axis.tvalid && in_load;
  assign clr           = (state_reg == ST_DONE);

  dp_axis_polyvec_loader_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_POLY   (NUM_POLY)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .adv       (accept),
    .clr       (clr),
    .wr_addr   (wr_addr),
    .poly_cnt  (poly_cnt),
    .addr_last (addr_last),
    .vec_last  (vec_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    o_done     = 1'b0;
    o_busy     = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_next = ST_LOAD;
      end
      ST_LOAD:  if (accept && vec_last) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_DONE;
      ST_DONE: begin
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_POLY; gi++) begin : g_we
    assign we_next[gi*NUM_BASE_BANK +: NUM_BASE_BANK] =
        {NUM_BASE_BANK{accept && (poly_cnt == PW'(gi))}};
  end

  // Address and data hold between accepts; only the strobes drop on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg     <= '0;
      wraddr_reg <= '0;
      data_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      we_reg <= we_next;
      if (accept) begin
        wraddr_reg <= {NUM_BASE_BANK{wr_addr}};
        data_reg   <= s_axis.tdata;
        if (s_axis.tlast != addr_last) err_reg <= 1'b1;
      end
    end
  end

  assign o_axi_we     = we_reg;
  assign o_axi_wraddr = wraddr_reg;
  assign o_axi_data   = data_reg;
  assign o_err        = err_reg;

endmodule

// File: tb/tb_dp_axis_polyvec_loader.sv
// Scoreboard bench for dp_axis_polyvec_loader (DEPTH=8, 3 polys, 8 banks).
`timescale 1ns/1ps
module tb_dp_axis_polyvec_loader;

  localparam int CW     = 39;
  localparam int AW     = 3;
  localparam int NP     = 3;
  localparam int NB     = 8;
  localparam int DEPTH  = 8;
  localparam int NBEATS = NP * DEPTH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic [NB*NP-1:0]  o_axi_we;
  logic [AW*NB-1:0]  o_axi_wraddr;
  logic [CW*NB-1:0]  o_axi_data;
  logic              o_done, o_busy, o_err;

  dp_axis_polyvec_loader_if #(.COE_WIDTH(CW), .NUM_BASE_BANK(NB)) axis ();

  dp_axis_polyvec_loader #(
    .COE_WIDTH(CW), .ADDR_WIDTH(AW), .NUM_POLY(NP), .NUM_BASE_BANK(NB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .s_axis       (axis),
    .o_axi_we     (o_axi_we),
    .o_axi_wraddr (o_axi_wraddr),
    .o_axi_data   (o_axi_data),
    .o_done       (o_done),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [NB*NP-1:0] we;
    logic [AW*NB-1:0] addr;
    logic [CW*NB-1:0] data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  wr_t mon_e;
  int  err_from = -1;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] row_addr(input int a);
    logic [AW-1:0] r;
    r = AW'(a);
`ifdef DP_LOADER_BITREV_EN
    case (a)
      0: r = 3'd0; 1: r = 3'd4; 2: r = 3'd2; 3: r = 3'd6;
      4: r = 3'd1; 5: r = 3'd5; 6: r = 3'd3; 7: r = 3'd7;
      default: r = 3'd0;
    endcase
`endif
    return r;
  endfunction

  function automatic logic [CW*NB-1:0] mk_data(input int beat);
    logic [CW*NB-1:0] d;
    d = '0;
    for (int b = 0; b < NB; b++) d[b*CW +: CW] = CW'(beat * 16 + b);
    return d;
  endfunction

  // Monitor: every strobe or done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (o_axi_we != '0) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 512'(o_axi_we), 512'(0));
      end else begin
        mon_e = wq.pop_front();
        $display("write cyc=%0d we=%h addr=%h err=%b", cyc, o_axi_we, o_axi_wraddr, o_err);
        chk("wr_cycle", 512'(cyc), 512'(mon_e.cyc));
        chk("wr_we", 512'(o_axi_we), 512'(mon_e.we));
        chk("wr_addr", 512'(o_axi_wraddr), 512'(mon_e.addr));
        chk("wr_data", 512'(o_axi_data), 512'(mon_e.data));
        chk("wr_err", 512'(o_err), 512'(err_from >= 0 && cyc >= err_from));
      end
    end
    if (o_done) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", 512'(o_done), 512'(0));
      end else begin
        $display("done cyc=%0d", cyc);
        chk("done_cycle", 512'(cyc), 512'(dq.pop_front()));
      end
    end
  end

  task automatic run_load(input bit gaps, input int bad_beat, input int stop_at, input int restart_beat);
    int beat = 0;
    int guard = 0;
    bit v;
    logic [NB*NP-1:0] w;
    @(posedge clk); #1;
    i_start = 1'b1;
    @(negedge clk);
    chk("tready_idle", 512'(axis.tready), 512'(0));
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    chk("busy_load", 512'(o_busy), 512'(1));
    chk("tready_load", 512'(axis.tready), 512'(1));
    @(posedge clk); #1;
    while (beat < stop_at && guard < 400) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      axis.tvalid = v;
      axis.tdata  = mk_data(beat);
      axis.tlast  = ((beat % DEPTH) == DEPTH - 1) ^ (beat == bad_beat);
      i_start     = (beat == restart_beat);
      @(negedge clk);
      if (v && axis.tready) begin
        w = '0;
        w[(beat / DEPTH) * NB +: NB] = '1;
        wq.push_back('{cyc: cyc + 1, we: w, addr: {NB{row_addr(beat % DEPTH)}}, data: mk_data(beat)});
        if (beat == bad_beat) err_from = cyc + 1;
        if (beat == NBEATS - 1) dq.push_back(cyc + 2);
        beat++;
      end
      guard++;
      @(posedge clk); #1;
    end
    if (guard >= 400) chk("beat_timeout", 512'(beat), 512'(stop_at));
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    i_start     = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((wq.size() != 0 || dq.size() != 0) && g < 50) begin
      @(posedge clk);
      g++;
    end
    chk("drain", 512'(wq.size() + dq.size()), 512'(0));
    @(negedge clk);
    chk("busy_idle", 512'(o_busy), 512'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    $display("%s cyc=%0d", tag, cyc);
    chk({tag, "_we"}, 512'(o_axi_we), 512'(0));
    chk({tag, "_wraddr"}, 512'(o_axi_wraddr), 512'(0));
    chk({tag, "_data"}, 512'(o_axi_data), 512'(0));
    chk({tag, "_done"}, 512'(o_done), 512'(0));
    chk({tag, "_busy"}, 512'(o_busy), 512'(0));
    chk({tag, "_err"}, 512'(o_err), 512'(0));
    chk({tag, "_tready"}, 512'(axis.tready), 512'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    axis.tdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Continuous stream.
    run_load(1'b0, -1, NBEATS, -1);
    drain();
    chk("err_clean", 512'(o_err), 512'(0));

    // Random valid gaps.
    run_load(1'b1, -1, NBEATS, -1);
    drain();

    // Reset after beat 10; the pending write still shows before reset lands.
    run_load(1'b0, -1, 10, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("midreset");
    chk("midreset_queue", 512'(wq.size() + dq.size()), 512'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    run_load(1'b0, -1, NBEATS, -1);
    drain();

    // i_start during LOAD is ignored, then tvalid in IDLE is refused.
    run_load(1'b0, -1, NBEATS, 12);
    drain();
    axis.tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("tready_idle_valid", 512'(axis.tready), 512'(0));
    end
    axis.tvalid = 1'b0;
    repeat (3) @(posedge clk);

    // Spurious tlast at poly 1, addr 5.
    run_load(1'b0, 13, NBEATS, -1);
    drain();
    chk("err_sticky", 512'(o_err), 512'(1));

    chk("final_queue", 512'(wq.size() + dq.size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
